// File: rtl/slc3_ctrl_pkg.sv
// Shared types for the SLC-3 fetch controller: state encoding, PC mux selects
// and the bundle of datapath control lines.
package slc3_ctrl_pkg;

  typedef enum logic [3:0] {
    HALTED    = 4'd0,
    S_18      = 4'd1,
    S_33_WAIT = 4'd2,
    S_33_LAST = 4'd3,
    S_35      = 4'd4,
    PAUSE_IR1 = 4'd5,
    PAUSE_IR2 = 4'd6
  } state_t;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       mio_en;
    logic       mem_oe_n;
    logic       mem_we_n;
  } ctrl_t;

  // Everything inactive; memory strobes are active-low so they idle high.
  localparam ctrl_t CTRL_IDLE = '{
    ld_mar: 1'b0, ld_mdr: 1'b0, ld_ir: 1'b0, ld_pc: 1'b0,
    gate_pc: 1'b0, gate_mdr: 1'b0, gate_alu: 1'b0, gate_marmux: 1'b0,
    pcmux: PCMUX_INC, mio_en: 1'b0, mem_oe_n: 1'b1, mem_we_n: 1'b1
  };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state -> control-line lookup for the fetch controller.
module ctrl_decode
  import slc3_ctrl_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      S_18: begin
        o_ctrl.gate_pc = 1'b1;
        o_ctrl.ld_mar  = 1'b1;
        o_ctrl.ld_pc   = 1'b1;
        o_ctrl.pcmux   = PCMUX_INC;
      end
      S_33_WAIT: begin
        o_ctrl.mio_en   = 1'b1;
        o_ctrl.mem_oe_n = 1'b0;
      end
      // MDR captures only on the final cycle of the read window.
      S_33_LAST: begin
        o_ctrl.mio_en   = 1'b1;
        o_ctrl.mem_oe_n = 1'b0;
        o_ctrl.ld_mdr   = 1'b1;
      end
      S_35: begin
        o_ctrl.gate_mdr = 1'b1;
        o_ctrl.ld_ir    = 1'b1;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// SLC-3 fetch sequencer: state register, memory wait counter and retired-fetch
// counter; control lines are decoded from the registered state only.
module fetch_control_unit
  import slc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int COUNT_W         = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Continue,
  output logic               LD_MAR,
  output logic               LD_MDR,
  output logic               LD_IR,
  output logic               LD_PC,
  output logic               GatePC,
  output logic               GateMDR,
  output logic               GateALU,
  output logic               GateMARMUX,
  output logic [1:0]         PCMUX,
  output logic               MIO_EN,
  output logic               Mem_OE,
  output logic               Mem_WE,
  output logic [3:0]         state_dbg,
  output logic [COUNT_W-1:0] instr_count
);

  // S_18 preloads the counter so WAIT plus LAST span exactly MEM_WAIT_CYCLES.
  localparam logic [3:0] WAIT_INIT =
    (MEM_WAIT_CYCLES > 1) ? 4'(MEM_WAIT_CYCLES - 2) : 4'd0;

  state_t             r_state;
  logic [3:0]         r_wait_cnt;
  logic [COUNT_W-1:0] r_instr_count;
  ctrl_t              w_ctrl;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= HALTED;
      r_wait_cnt    <= 4'd0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        HALTED:    if (Run) r_state <= S_18;
        S_18: begin
          if (MEM_WAIT_CYCLES == 1) begin
            r_state <= S_33_LAST;
          end else begin
            r_state    <= S_33_WAIT;
            r_wait_cnt <= WAIT_INIT;
          end
        end
        S_33_WAIT: begin
          if (r_wait_cnt == 4'd0) r_state <= S_33_LAST;
          else                    r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        S_33_LAST: r_state <= S_35;
        S_35: begin
          r_state       <= PAUSE_IR1;
          r_instr_count <= r_instr_count + COUNT_W'(1);
        end
        // Press then release of Continue yields exactly one new fetch.
        PAUSE_IR1: if (Continue)  r_state <= PAUSE_IR2;
        PAUSE_IR2: if (!Continue) r_state <= S_18;
        default:   r_state <= HALTED;
      endcase
    end
  end

  ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign LD_MAR      = w_ctrl.ld_mar;
  assign LD_MDR      = w_ctrl.ld_mdr;
  assign LD_IR       = w_ctrl.ld_ir;
  assign LD_PC       = w_ctrl.ld_pc;
  assign GatePC      = w_ctrl.gate_pc;
  assign GateMDR     = w_ctrl.gate_mdr;
  assign GateALU     = w_ctrl.gate_alu;
  assign GateMARMUX  = w_ctrl.gate_marmux;
  assign PCMUX       = w_ctrl.pcmux;
  assign MIO_EN      = w_ctrl.mio_en;
  assign Mem_OE      = w_ctrl.mem_oe_n;
  assign Mem_WE      = w_ctrl.mem_we_n;
  assign state_dbg   = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: two builds (wait=2/16-bit count, wait=1/4-bit
// count) share one stimulus stream and are checked against a fetch-phase model.
module tb_fetch_control_unit;

  logic Clk = 1'b0;
  logic Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
  always #5 Clk = ~Clk;

  logic a_LD_MAR, a_LD_MDR, a_LD_IR, a_LD_PC, a_GatePC, a_GateMDR, a_GateALU, a_GateMARMUX;
  logic a_MIO_EN, a_Mem_OE, a_Mem_WE;
  logic [1:0] a_PCMUX;
  logic [3:0] a_state;
  logic [15:0] a_cnt;
  logic b_LD_MAR, b_LD_MDR, b_LD_IR, b_LD_PC, b_GatePC, b_GateMDR, b_GateALU, b_GateMARMUX;
  logic b_MIO_EN, b_Mem_OE, b_Mem_WE;
  logic [1:0] b_PCMUX;
  logic [3:0] b_state;
  logic [3:0] b_cnt;

  fetch_control_unit #(.MEM_WAIT_CYCLES(2), .COUNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .LD_MAR(a_LD_MAR), .LD_MDR(a_LD_MDR), .LD_IR(a_LD_IR), .LD_PC(a_LD_PC),
    .GatePC(a_GatePC), .GateMDR(a_GateMDR), .GateALU(a_GateALU), .GateMARMUX(a_GateMARMUX),
    .PCMUX(a_PCMUX), .MIO_EN(a_MIO_EN), .Mem_OE(a_Mem_OE), .Mem_WE(a_Mem_WE),
    .state_dbg(a_state), .instr_count(a_cnt)
  );

  fetch_control_unit #(.MEM_WAIT_CYCLES(1), .COUNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .LD_MAR(b_LD_MAR), .LD_MDR(b_LD_MDR), .LD_IR(b_LD_IR), .LD_PC(b_LD_PC),
    .GatePC(b_GatePC), .GateMDR(b_GateMDR), .GateALU(b_GateALU), .GateMARMUX(b_GateMARMUX),
    .PCMUX(b_PCMUX), .MIO_EN(b_MIO_EN), .Mem_OE(b_Mem_OE), .Mem_WE(b_Mem_WE),
    .state_dbg(b_state), .instr_count(b_cnt)
  );

  logic [53:0] obs;
  assign obs = {a_state, a_LD_MAR, a_LD_MDR, a_LD_IR, a_LD_PC, a_GatePC, a_GateMDR, a_GateALU,
                a_GateMARMUX, a_PCMUX, a_MIO_EN, a_Mem_OE, a_Mem_WE, a_cnt,
                b_state, b_LD_MAR, b_LD_MDR, b_LD_IR, b_LD_PC, b_GatePC, b_GateMDR, b_GateALU,
                b_GateMARMUX, b_PCMUX, b_MIO_EN, b_Mem_OE, b_Mem_WE, b_cnt};

  int checks = 0;
  int passes = 0;

  // Model: mode 0 halted, 1 fetching (k = cycles since fetch start), 2 waiting
  // for Continue press, 3 waiting for release. Index 0 = dut_a, 1 = dut_b.
  int m_mode[2] = '{0, 0};
  int m_k[2]    = '{0, 0};
  int m_cnt[2]  = '{0, 0};

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int w = (i == 0) ? 2 : 1;
      int modulus = (i == 0) ? 65536 : 16;
      if (Reset) begin
        m_mode[i] = 0;
        m_cnt[i]  = 0;
      end else begin
        case (m_mode[i])
          0: if (Run) begin m_mode[i] = 1; m_k[i] = 0; end
          1: if (m_k[i] == w + 1) begin
               m_mode[i] = 2;
               m_cnt[i]  = (m_cnt[i] + 1) % modulus;
             end else m_k[i]++;
          2: if (Continue) m_mode[i] = 3;
          3: if (!Continue) begin m_mode[i] = 1; m_k[i] = 0; end
          default: m_mode[i] = 0;
        endcase
      end
    end
  endtask

  // Expected {state, 8 load/gate lines, PCMUX, MIO_EN, Mem_OE, Mem_WE}.
  function automatic logic [16:0] exp_ctl(int i);
    int w = (i == 0) ? 2 : 1;
    logic [3:0] st = 4'd0;
    logic [7:0] lg = 8'h00;
    logic mio = 1'b0;
    logic oe = 1'b1;
    case (m_mode[i])
      1: begin
        if (m_k[i] == 0) begin
          st = 4'd1; lg = 8'b1001_1000;
        end else if (m_k[i] <= w) begin
          st = (m_k[i] == w) ? 4'd3 : 4'd2;
          mio = 1'b1; oe = 1'b0;
          if (m_k[i] == w) lg = 8'b0100_0000;
        end else begin
          st = 4'd4; lg = 8'b0010_0100;
        end
      end
      2: st = 4'd5;
      3: st = 4'd6;
      default: st = 4'd0;
    endcase
    return {st, lg, 2'b00, mio, oe, 1'b1};
  endfunction

  function automatic logic [53:0] expect_all();
    return {exp_ctl(0), 16'(m_cnt[0]), exp_ctl(1), 4'(m_cnt[1])};
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    checks++;
    if (a_state !== 4'd0 || a_cnt !== 16'd0 || a_Mem_OE !== 1'b1 || a_Mem_WE !== 1'b1 ||
        {a_LD_MAR, a_LD_MDR, a_LD_IR, a_LD_PC, a_GatePC, a_GateMDR, a_GateALU, a_GateMARMUX} !== 8'h00)
      $display("FAIL reset_state got state=%0d cnt=%0d oe=%b we=%b", a_state, a_cnt, a_Mem_OE, a_Mem_WE);
    else passes++;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== expect_all()) $display("FAIL halted_idle cyc=%0d got=%h exp=%h", c, obs, expect_all());
      else passes++;
    end
  endtask

  task automatic test_first_fetch();
    Run = 1'b1;
    tick();
    Run = 1'b0;
    checks++;
    if (obs !== expect_all()) $display("FAIL fetch_s18 got=%h exp=%h", obs, expect_all());
    else passes++;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs !== expect_all()) $display("FAIL first_fetch cyc=%0d got=%h exp=%h", c, obs, expect_all());
      else passes++;
    end
    checks++;
    if (a_cnt !== 16'd1 || b_cnt !== 4'd1 || a_state !== 4'd5)
      $display("FAIL first_fetch_count got a=%0d b=%0d st=%0d exp a=1 b=1 st=5", a_cnt, b_cnt, a_state);
    else passes++;
  endtask

  task automatic test_continue_hold();
    Continue = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs !== expect_all()) $display("FAIL continue_held cyc=%0d got=%h exp=%h", c, obs, expect_all());
      else passes++;
    end
    Continue = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs !== expect_all()) $display("FAIL continue_release cyc=%0d got=%h exp=%h", c, obs, expect_all());
      else passes++;
    end
    checks++;
    if (a_cnt !== 16'd2 || b_cnt !== 4'd2 || a_state !== 4'd5)
      $display("FAIL one_fetch_per_press got a=%0d b=%0d st=%0d exp a=2 b=2 st=5", a_cnt, b_cnt, a_state);
    else passes++;
  endtask

  task automatic test_reset_midwait();
    bit found = 1'b0;
    Continue = 1'b1; tick();
    Continue = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (a_state === 4'd2) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL reach_s33_wait got state=%0d exp=2", a_state);
    else passes++;
    Reset = 1'b1; tick(); Reset = 1'b0;
    checks++;
    if (a_state !== 4'd0 || a_Mem_OE !== 1'b1 || a_cnt !== 16'd0 || b_cnt !== 4'd0)
      $display("FAIL reset_midwait got state=%0d oe=%b cnt=%0d exp state=0 oe=1 cnt=0", a_state, a_Mem_OE, a_cnt);
    else passes++;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs !== expect_all() || a_LD_MDR !== 1'b0 || a_LD_IR !== 1'b0)
        $display("FAIL post_reset_quiet cyc=%0d got=%h exp=%h", c, obs, expect_all());
      else passes++;
    end
  endtask

  task automatic test_wrap();
    Run = 1'b1; tick(); Run = 1'b0;
    for (int f = 0; f < 16; f++) begin
      bit paused = 1'b0;
      for (int c = 0; c < 20 && !paused; c++) begin
        tick();
        checks++;
        if (obs !== expect_all() ||
            $countones({a_GatePC, a_GateMDR, a_GateALU, a_GateMARMUX}) > 1 ||
            $countones({b_GatePC, b_GateMDR, b_GateALU, b_GateMARMUX}) > 1 ||
            (a_Mem_OE === 1'b0 && a_MIO_EN !== 1'b1) || (b_LD_MDR === 1'b1 && b_Mem_OE !== 1'b0))
          $display("FAIL wrap_cycle f=%0d got=%h exp=%h", f, obs, expect_all());
        else passes++;
        if (a_state === 4'd5 && b_state === 4'd5) paused = 1'b1;
      end
      checks++;
      if (!paused) $display("FAIL wrap_reach_pause f=%0d got a=%0d b=%0d exp 5", f, a_state, b_state);
      else passes++;
      if (f < 15) begin
        Continue = 1'b1; tick();
        Continue = 1'b0; tick();
      end
    end
    checks++;
    if (b_cnt !== 4'd0 || a_cnt !== 16'd16)
      $display("FAIL count_wrap got b=%0d a=%0d exp b=0 a=16", b_cnt, a_cnt);
    else passes++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      Run      = ($urandom_range(0, 3) == 0);
      Continue = $urandom_range(0, 1) != 0;
      Reset    = ($urandom_range(0, 40) == 0);
      tick();
      checks++;
      if (obs !== expect_all()) $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, expect_all());
      else passes++;
    end
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_continue_hold();
    test_reset_midwait();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
